// File: rtl/i2s_output_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_output_if : sample stream (stb/ack) plus I2S bus of the transmitter  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface i2s_output_if;
    logic [31:0] in1;
    logic        in1_stb;
    logic        in1_ack;
    logic        bclk;
    logic        lrclk;
    logic        dout;
    logic        underrun;

    modport master (
        output in1, in1_stb,
        input  in1_ack, bclk, lrclk, dout, underrun
    );

    modport slave (
        input  in1, in1_stb,
        output in1_ack, bclk, lrclk, dout, underrun
    );
endinterface
`default_nettype wire

// File: rtl/i2s_output.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_output : I2S bus master, 16-bit stereo, 32 BCLK slots per channel    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2s_output #(
    parameter int BCLK_DIV = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    i2s_output_if.slave s_bus
);
    localparam int                 C_DIV_W   = $clog2(BCLK_DIV);
    localparam logic [C_DIV_W-1:0] C_DIV_MAX = C_DIV_W'(BCLK_DIV - 1);

    logic [C_DIV_W-1:0] div_q, div_d;
    logic [5:0]         slot_q, slot_d;
    logic [31:0]        hold_q, hold_d;
    logic [31:0]        shift_q, shift_d;
    logic               hv_q, hv_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               dout_q, dout_d;
    logic               underrun_q, underrun_d;
    logic               in1_ack_q, in1_ack_d;

    logic               w_wrap;
    logic               w_fall;
    logic               w_frame_start;
    logic               w_xfer;
    logic [4:0]         w_bit_idx;

    always_comb begin
        w_wrap        = (div_q == C_DIV_MAX);
        w_fall        = w_wrap && bclk_q;
        w_xfer        = s_bus.in1_stb && in1_ack_q;

        div_d         = w_wrap ? '0 : div_q + C_DIV_W'(1);
        bclk_d        = bclk_q ^ w_wrap;
        slot_d        = w_fall ? slot_q + 6'd1 : slot_q;
        w_frame_start = w_fall && (slot_d == 6'd0);

        shift_d       = shift_q;
        hold_d        = hold_q;
        hv_d          = hv_q;
        underrun_d    = 1'b0;

        // Frame start consumes the old holding word before a same-cycle transfer refills it.
        if (w_frame_start) begin
            shift_d    = hv_q ? hold_q : 32'd0;
            underrun_d = !hv_q;
            hv_d       = 1'b0;
        end
        if (w_xfer) begin
            hold_d = s_bus.in1;
            hv_d   = 1'b1;
        end
        in1_ack_d = !hv_d;

        // Slots 0..15 map to bits 31..16, slots 32..47 to bits 15..0.
        w_bit_idx = {~slot_d[5], ~slot_d[3:0]};
        lrclk_d   = lrclk_q;
        dout_d    = dout_q;
        if (w_fall) begin
            lrclk_d = (slot_d >= 6'd31) && (slot_d <= 6'd62);
            dout_d  = (slot_d[4] == 1'b0) ? shift_d[w_bit_idx] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            slot_q     <= 6'd63;
            hold_q     <= 32'd0;
            shift_q    <= 32'd0;
            hv_q       <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
            in1_ack_q  <= 1'b1;
        end else begin
            div_q      <= div_d;
            slot_q     <= slot_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            hv_q       <= hv_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
            in1_ack_q  <= in1_ack_d;
        end
    end

    assign s_bus.bclk     = bclk_q;
    assign s_bus.lrclk    = lrclk_q;
    assign s_bus.dout     = dout_q;
    assign s_bus.underrun = underrun_q;
    assign s_bus.in1_ack  = in1_ack_q;
endmodule
`default_nettype wire
